ext_ram_reader: RTL

- Read-side sequencer for the extrinsic-message RAM in the LDPC decoder.
- On a start command it streams a contiguous address range out of the single-port, synchronous-read RAM as a valid/ready stream.
- Drives the RAM's clk-domain cs/we/address pins and absorbs the RAM's 1-cycle read latency with a 2-entry buffer, so downstream backpressure never drops or duplicates a word.
- Sits between the EXT RAM instance and the check/variable-node processing units.

---
 rtl/ext_ram_pkg.sv | 23 ++
 rtl/ext_rd_skid_fifo.sv | 62 ++++++
 rtl/ext_ram_reader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ext_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_ram_pkg
// Description : Shared types and constants for the EXT RAM read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_ram_pkg;

    localparam int EXT_DATA_WIDTH   = 8;
    localparam int EXT_ADDR_WIDTH   = 8;
    localparam int EXT_RD_BUF_DEPTH = 2;
    localparam int EXT_RD_CNT_W     = $clog2(EXT_RD_BUF_DEPTH + 1);
    localparam int EXT_RD_PTR_W     = $clog2(EXT_RD_BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ext_rd_state_e;

endpackage
`default_nettype wire

// File: rtl/ext_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ext_rd_skid_fifo
// Description : Small synchronous FIFO absorbing the RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_rd_skid_fifo
    import ext_ram_pkg::*;
#(
    parameter int DATA_WIDTH = EXT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic [EXT_RD_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0]   mem_q [EXT_RD_BUF_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [EXT_RD_BUF_DEPTH];
    logic [EXT_RD_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [EXT_RD_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [EXT_RD_CNT_W-1:0] count_q, count_d;

    // Caller guarantees no push when full and no pop when empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + EXT_RD_PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + EXT_RD_PTR_W'(1);
        end
        count_d = count_q + EXT_RD_CNT_W'(push) - EXT_RD_CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < EXT_RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/ext_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : ext_ram_reader
// Description : Streams a contiguous address range out of the EXT RAM as a
//               valid/ready stream. EXT_RD_LAST_EN adds the m_last output.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_ram_reader
    import ext_ram_pkg::*;
#(
    parameter int DATA_WIDTH = EXT_DATA_WIDTH,
    parameter int ADDR_WIDTH = EXT_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
`ifdef EXT_RD_LAST_EN
    output logic                  m_last,
`endif
    input  logic                  m_ready
);

    localparam int LEN_W = $clog2(RAM_DEPTH) + 1;

    ext_rd_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    inflight_q, inflight_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [EXT_RD_CNT_W-1:0] buf_count;
    logic [2:0]              occupancy;
    logic                    pop;
    logic                    issue;

    assign pop       = m_valid & m_ready;
    assign occupancy = {1'b0, buf_count} + {2'b0, inflight_q};
    // Credit check: a word issued now lands in the buffer next cycle.
    assign issue     = (state_q == ST_READ) &&
                       (occupancy < (3'(EXT_RD_BUF_DEPTH) + {2'b0, pop}));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (pop) begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        ptr_d       = base_addr;
                        issue_cnt_d = len;
                        beat_cnt_d  = len;
                        busy_d      = 1'b1;
                        state_d     = ST_READ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    ptr_d       = ptr_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - LEN_W'(1);
                    if (issue_cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_cnt_d == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    ext_rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (ram_rdata),
        .pop       (pop),
        .pop_data  (m_data),
        .count     (buf_count)
    );

    assign m_valid  = (buf_count != '0);
    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_cs   = issue;
    assign ram_we   = 1'b0;
    assign ram_addr = ptr_q;

`ifdef EXT_RD_LAST_EN
    assign m_last = m_valid && (beat_cnt_q == LEN_W'(1));
`endif

endmodule
`default_nettype wire
